// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and presents PC/IR
// (or a NOP bubble) to the IF/ID pipeline register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_pc,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic        Imem_ack,
    input  logic [31:0] Imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] IR_out,
    output logic        Valid_out,
    output logic        Addr_err
);

    typedef enum logic [1:0] {StFetch, StHold, StDiscard} state_t;

    localparam logic [31:0] Step = 32'(PC_STEP);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic [31:0] target;

    assign pc_seq = pc + Step;
    assign target = {Redirect_pc[31:2], 2'b00};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= StFetch;
            pc        <= RESET_PC;
            Imem_req  <= 1'b0;
            Imem_addr <= RESET_PC;
            PC_out    <= 32'h0;
            IR_out    <= 32'h0;
            Valid_out <= 1'b0;
            Addr_err  <= 1'b0;
        end else if (Redirect) begin
            pc        <= target;
            Addr_err  <= Addr_err | (|Redirect_pc[1:0]);
            PC_out    <= 32'h0;
            IR_out    <= 32'h0;
            Valid_out <= 1'b0;
            // An unacknowledged request belongs to the memory: keep it up and drop its data.
            if (Imem_req && !Imem_ack) begin
                state <= StDiscard;
            end else begin
                state     <= StFetch;
                Imem_req  <= 1'b1;
                Imem_addr <= target;
            end
        end else begin
            unique case (state)
                StFetch: begin
                    if (!Imem_req) begin
                        // First cycle out of reset; any ack seen now is stale.
                        Imem_req  <= 1'b1;
                        Imem_addr <= pc;
                    end else if (Imem_ack) begin
                        state     <= StHold;
                        Imem_req  <= 1'b0;
                        Valid_out <= 1'b1;
                        IR_out    <= Imem_rdata;
                        PC_out    <= pc_seq;
                    end
                end
                StHold: begin
                    if (!Stall) begin
                        state     <= StFetch;
                        pc        <= pc_seq;
                        Imem_req  <= 1'b1;
                        Imem_addr <= pc_seq;
                        PC_out    <= 32'h0;
                        IR_out    <= 32'h0;
                        Valid_out <= 1'b0;
                    end
                end
                StDiscard: begin
                    if (Imem_ack) begin
                        state     <= StFetch;
                        Imem_addr <= pc;
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model.
module tb_if_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Stall;
    logic        Redirect;
    logic [31:0] Redirect_pc;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ack;
    logic [31:0] Imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] IR_out;
    logic        Valid_out;
    logic        Addr_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: request outstanding (address, drop flag) and instruction presented.
    logic [31:0] m_pc, m_addr, m_ir, m_pcout;
    logic        m_req, m_drop, m_valid, m_err;

    always #5 Clk = ~Clk;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Stall       (Stall),
        .Redirect    (Redirect),
        .Redirect_pc (Redirect_pc),
        .Imem_req    (Imem_req),
        .Imem_addr   (Imem_addr),
        .Imem_ack    (Imem_ack),
        .Imem_rdata  (Imem_rdata),
        .PC_out      (PC_out),
        .IR_out      (IR_out),
        .Valid_out   (Valid_out),
        .Addr_err    (Addr_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_addr = 32'h0; m_ir = 32'h0; m_pcout = 32'h0;
        m_req = 1'b0; m_drop = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic ack_eff;
        ack_eff = Imem_ack && m_req;
        if (Redirect) begin
            m_err   = m_err || (Redirect_pc[1:0] != 2'b00);
            m_pc    = Redirect_pc & ~32'h3;
            m_valid = 1'b0; m_ir = 32'h0; m_pcout = 32'h0;
            if (m_req && !ack_eff) begin
                m_drop = 1'b1;
            end else begin
                m_drop = 1'b0; m_req = 1'b1; m_addr = m_pc;
            end
        end else if (m_valid) begin
            if (!Stall) begin
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b0; m_ir = 32'h0; m_pcout = 32'h0;
                m_req   = 1'b1; m_addr = m_pc;
            end
        end else if (!m_req) begin
            m_req = 1'b1; m_addr = m_pc;
        end else if (ack_eff) begin
            if (m_drop) begin
                m_drop = 1'b0; m_addr = m_pc;
            end else begin
                m_req = 1'b0; m_valid = 1'b1; m_ir = Imem_rdata; m_pcout = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".req"},   32'(Imem_req),  32'(m_req));
        check({ctx, ".addr"},  Imem_addr,      m_addr);
        check({ctx, ".valid"}, 32'(Valid_out), 32'(m_valid));
        check({ctx, ".ir"},    IR_out,         m_ir);
        check({ctx, ".pc"},    PC_out,         m_pcout);
        check({ctx, ".err"},   32'(Addr_err),  32'(m_err));
    endtask

    task automatic step(input string ctx);
        if (Rst_n) model_edge();
        @(posedge Clk);
        #1;
        compare_all(ctx);
    endtask

    initial begin
        logic [31:0] r;
        Rst_n = 1'b0; Stall = 1'b0; Redirect = 1'b0; Redirect_pc = 32'h0;
        Imem_ack = 1'b0; Imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        compare_all("reset");

        // Basic fetch: ack one cycle after the request.
        Rst_n = 1'b1;
        step("release");
        check("first_addr", Imem_addr, 32'h0);
        check("first_req", 32'(Imem_req), 32'd1);
        Imem_ack = 1'b1; Imem_rdata = 32'h2008_0005;
        step("t1_ack");
        Imem_ack = 1'b0;
        check("t1_ir", IR_out, 32'h2008_0005);
        check("t1_pc", PC_out, 32'h4);
        step("t1_next");
        check("t1_next_addr", Imem_addr, 32'h4);

        // Stall held three cycles in HOLD.
        Imem_ack = 1'b1; Imem_rdata = 32'hABCD_0001;
        step("t2_ack");
        Imem_ack = 1'b0; Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("t2_stall");
            check("t2_stall_pc", PC_out, 32'h8);
            check("t2_stall_req", 32'(Imem_req), 32'd0);
        end
        Stall = 1'b0;
        step("t2_go");
        check("t2_go_addr", Imem_addr, 32'h8);

        // Redirect while a request is outstanding; late data must be dropped.
        Redirect = 1'b1; Redirect_pc = 32'h0000_0040;
        step("t3_redir");
        Redirect = 1'b0;
        step("t3_wait");
        Imem_ack = 1'b1; Imem_rdata = 32'hDEAD_BEEF;
        step("t3_ack");
        Imem_ack = 1'b0;
        check("t3_no_deadbeef", IR_out, 32'h0);
        check("t3_new_addr", Imem_addr, 32'h40);

        // Redirect and ack in the same cycle.
        Redirect = 1'b1; Redirect_pc = 32'h0000_0080; Imem_ack = 1'b1; Imem_rdata = 32'h1111_2222;
        step("t4_both");
        Redirect = 1'b0; Imem_ack = 1'b0;
        check("t4_addr", Imem_addr, 32'h80);
        check("t4_valid", 32'(Valid_out), 32'd0);

        // Redirect beats Stall in HOLD.
        Imem_ack = 1'b1; Imem_rdata = 32'h3333_4444;
        step("t5_ack");
        Imem_ack = 1'b0; Stall = 1'b1; Redirect = 1'b1; Redirect_pc = 32'h0000_0100;
        step("t5_redir");
        Stall = 1'b0; Redirect = 1'b0;
        check("t5_valid", 32'(Valid_out), 32'd0);
        check("t5_addr", Imem_addr, 32'h100);

        // Misaligned target: sticky error, aligned fetch.
        Redirect = 1'b1; Redirect_pc = 32'h0000_0046; Imem_ack = 1'b1; Imem_rdata = 32'h5555_5555;
        step("t6_mis");
        Redirect = 1'b0; Imem_ack = 1'b0;
        check("t6_addr", Imem_addr, 32'h44);
        step("t6_hold");
        check("t6_sticky", 32'(Addr_err), 32'd1);

        // PC wraps from the top of the address space.
        Redirect = 1'b1; Redirect_pc = 32'hFFFF_FFFC; Imem_ack = 1'b1;
        step("t7_redir");
        Redirect = 1'b0; Imem_rdata = 32'h7777_7777;
        step("t7_ack");
        Imem_ack = 1'b0;
        check("t7_pc_wrap", PC_out, 32'h0);
        step("t7_next");
        check("t7_addr_wrap", Imem_addr, 32'h0);

        // Asynchronous reset mid-request; a stale ack afterwards is ignored.
        Rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t8_async");
        Imem_ack = 1'b1;
        @(posedge Clk);
        #1;
        compare_all("t8_in_rst");
        Rst_n = 1'b1;
        step("t8_stale");
        Imem_ack = 1'b0;
        check("t8_valid", 32'(Valid_out), 32'd0);
        check("t8_addr", Imem_addr, 32'h0);

        // Randomized traffic; every presented word must match memory at PC_out-4.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            Stall       = ($urandom_range(0, 2) == 0);
            Redirect    = ($urandom_range(0, 9) == 0);
            Redirect_pc = ($urandom_range(0, 7) == 0) ? r : (r & ~32'h3);
            Imem_ack    = m_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            Imem_rdata  = m_req ? mem_word(m_addr) : $urandom;
            step("rnd");
            if (Valid_out) check("rnd_ir_vs_mem", IR_out, mem_word(PC_out - 32'd4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter, fetches words from instruction memory over a req/ack handshake, and presents PC/IR to the IF/ID pipeline register.
- Producer side of the IF/ID interface. Obeys the same Stall (hold) and redirect/flush semantics the IF/ID register uses.
- Inserts NOP bubbles (IR=0, PC=0) whenever no fetched instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Stall  in  1  hazard-unit hold; IF/ID does not capture while high.
- Redirect  in  1  one-cycle pulse; branch/jump taken, fetch restarts at Redirect_pc.
- Redirect_pc  in  32  redirect target, valid when Redirect=1.
- Imem_req  out  1  fetch request, held until ack.
- Imem_addr  out  32  fetch address, stable while Imem_req=1.
- Imem_ack  in  1  one-cycle pulse, Imem_rdata valid.
- Imem_rdata  in  32  fetched instruction word.
- PC_out  out  32  PC+PC_STEP of the presented instruction (0 when bubble).
- IR_out  out  32  presented instruction (0 when bubble).
- Valid_out  out  1  PC_out/IR_out hold a real instruction.
- Addr_err  out  1  sticky: a misaligned redirect target was received.

Behaviour:
- Reset (async, Rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - Imem_req=0, Imem_addr=RESET_PC.
  - PC_out=0, IR_out=0, Valid_out=0, Addr_err=0.
- Imem_req is registered. It rises the first edge after Rst_n deasserts.
- States:
  - FETCH: Imem_req=1, Imem_addr=pc. Outputs show a bubble (Valid_out=0, PC_out=0, IR_out=0).
  - HOLD: Imem_req=0. Outputs present the fetched instruction.
  - DISCARD: Imem_req=1 kept until ack, because the memory owns the request. Imem_addr holds the old address. Outputs show a bubble.
- FETCH transitions:
  - Imem_ack=1 -> HOLD. Next cycle: Valid_out=1, IR_out=Imem_rdata, PC_out=pc+PC_STEP, Imem_req=0.
- HOLD transitions:
  - Stall=0: the instruction is consumed by IF/ID at this edge. pc<=pc+PC_STEP (mod 2^32, wrap silently), state -> FETCH, outputs return to bubble.
  - Stall=1: outputs and pc held unchanged.
- Redirect (highest priority, any state):
  - pc<=Redirect_pc and outputs -> bubble next cycle.
  - FETCH with Imem_ack=0 -> DISCARD.
  - FETCH with Imem_ack=1 in the same cycle -> data dropped, state -> FETCH at the new pc.
  - HOLD -> FETCH, presented instruction discarded regardless of Stall.
  - DISCARD -> stays in DISCARD, pc updated to the newest target.
- DISCARD transitions:
  - Imem_ack=1 (no Redirect) -> data dropped, state -> FETCH at pc.
- Redirect vs Stall:
  - Redirect wins over Stall.
  - Stall has no effect in FETCH/DISCARD, since the outputs are already a bubble.
- Alignment:
  - If Redirect_pc[1:0]!=0, Addr_err sets and stays set until reset.
  - pc is loaded with Redirect_pc & ~3, so fetch continues aligned.
- Latency and throughput:
  - Ack at edge N -> Valid_out at N+1. A zero-wait memory gives 1 instruction per 2 cycles.
  - At most one request outstanding; no prefetch.
- Imem_ack while Imem_req=0 is ignored.
- Reset asserted mid-request: everything returns to reset values immediately. Any later stale ack is ignored until Imem_req is reasserted.

Test Plan:
- Reset release, memory acks 1 cycle after req with 32'h2008_0005 -> Imem_addr=0, then Valid_out=1, IR_out=32'h2008_0005, PC_out=4; with Stall=0, next Imem_addr=4.
- Stall=1 held 3 cycles while in HOLD -> PC_out/IR_out/Valid_out unchanged and Imem_req=0 throughout; Stall=0 -> next fetch address = previous+4.
- Redirect to 32'h0000_0040 while a request is outstanding (ack 2 cycles later with 32'hDEAD_BEEF) -> DEADBEEF never appears on IR_out; the next request is addr 0x40.
- Redirect and Imem_ack in the same cycle -> data dropped; next cycle Imem_req=1, Imem_addr=Redirect_pc; Valid_out stays 0.
- Redirect with Stall=1 while in HOLD -> Valid_out=0 next cycle; fetch at the target.
- Redirect_pc=32'h0000_0046 -> Addr_err=1 (sticky); fetch addr=32'h0000_0044.
- Sequential fetch from pc=32'hFFFF_FFFC -> next Imem_addr=0.
- Rst_n pulsed low mid-wait -> outputs asynchronously zero, Imem_req=0; after release, fetch restarts at RESET_PC.
